// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types used by the write-through data cache:
//   word_t          32-bit machine word
//   dcache_state_t  cache controller states (IDLE, RD, WR, FLUSHED)
//   dcache_frame_t  one direct-mapped frame {valid, tag, data}
// The frame tag field is sized for the widest possible tag (word address
// width); narrower tags are zero-extended so the struct stays parameter-free.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Word address width: byte address bits [31:2].
    localparam int WORD_ADDR_W = 30;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        FLUSHED = 2'd3
    } dcache_state_t;

    typedef struct packed {
        logic       valid;
        word_addr_t tag;
        word_t      data;
    } dcache_frame_t;

    // Strip the byte offset from a byte address.
    function automatic word_addr_t word_addr(input word_t byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dcache_link_reg.sv
// ---------------------------------------------------------------------------
// dcache_link_reg
// LL/SC link register: {valid, word address}.
// Ports:
//   CLK, RST        clock, synchronous active-high reset (clears the link)
//   ll_done_i       an LL read completes this cycle; link <= {1, ll_addr_i}
//   ll_addr_i       word address of the completing LL
//   sc_done_i       an SC completes this cycle (success or fail); link cleared
//   wr_done_i       a memory write completes this cycle
//   wr_addr_i       word address of the completing write
//   sc_addr_i       word address of the SC currently presented
//   match_o         link valid and linked address equals sc_addr_i
// ---------------------------------------------------------------------------
module dcache_link_reg
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ll_done_i,
    input  word_addr_t ll_addr_i,
    input  logic       sc_done_i,
    input  logic       wr_done_i,
    input  word_addr_t wr_addr_i,
    input  word_addr_t sc_addr_i,
    output logic       match_o
);

    logic       link_valid_q;
    word_addr_t link_addr_q;
    logic       link_clear;

    // A completed write to the linked word breaks the reservation, as does
    // finishing any SC attempt.
    assign link_clear = sc_done_i
                      | (wr_done_i && link_valid_q && (wr_addr_i == link_addr_q));

    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else if (ll_done_i) begin
            link_valid_q <= 1'b1;
            link_addr_q  <= ll_addr_i;
        end else if (link_clear) begin
            link_valid_q <= 1'b0;
        end
    end

    assign match_o = link_valid_q && (link_addr_q == sc_addr_i);

endmodule

// File: rtl/dcache_wt.sv
// ---------------------------------------------------------------------------
// dcache_wt
// Direct-mapped, one-word-per-frame, write-through / no-write-allocate data
// cache with LL/SC support and a halt-driven flush handshake.
// Parameters:
//   NFRAMES   number of frames (power of two, 2..64)
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   halt                      datapath stop request; leads to flushed
//   dmemREN, dmemWEN          datapath read / write request (held until dhit)
//   datomic                   LL with dmemREN, SC with dmemWEN
//   dmemaddr, dmemstore       byte address / store data
//   dhit, dmemload            request complete / read data or SC result
//   flushed                   sticky quiescent indication
//   dREN, dWEN, daddr, dstore memory request side
//   dwait, dload              memory busy / memory read data
// ---------------------------------------------------------------------------
module dcache_wt
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int IW    = $clog2(NFRAMES);
    localparam int TAG_W = WORD_ADDR_W - IW;

    dcache_state_t state_q, state_d;
    dcache_frame_t frames_q [NFRAMES];
    logic          sc_q;

    logic [IW-1:0]    index;
    logic [TAG_W-1:0] tag_raw;
    word_addr_t       tag_ext;
    word_addr_t       req_waddr;
    dcache_frame_t    cur_frame;
    logic             tag_hit;
    logic             is_read;
    logic             is_write;
    logic             is_ll;
    logic             is_sc;
    logic             link_match;
    logic             sc_fail;
    logic             xfer_done;
    logic             frame_we;
    dcache_frame_t    frame_wdata;
    logic             unused_byte_offset;

    // Address decode
    assign index     = dmemaddr[2+IW-1:2];
    assign tag_raw   = dmemaddr[31:2+IW];
    assign tag_ext   = {{IW{1'b0}}, tag_raw};
    assign req_waddr = word_addr(dmemaddr);
    assign unused_byte_offset = ^dmemaddr[1:0];

    assign cur_frame = frames_q[index];
    assign tag_hit   = cur_frame.valid && (cur_frame.tag == tag_ext);

    // A simultaneous read and write request is served as the write alone.
    assign is_write = dmemWEN;
    assign is_read  = dmemREN && !dmemWEN;
    assign is_ll    = is_read && datomic;
    assign is_sc    = is_write && datomic;
    assign sc_fail  = is_sc && !link_match;

    assign xfer_done = ((state_q == RD) || (state_q == WR)) && !dwait;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_write && !sc_fail) begin
                    state_d = WR;
                end else if (is_read && !tag_hit) begin
                    state_d = RD;
                end else if (halt && !dmemREN && !dmemWEN) begin
                    state_d = FLUSHED;
                end
            end
            RD: begin
                if (!dwait) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (!dwait) begin
                    state_d = IDLE;
                end
            end
            FLUSHED: begin
                state_d = FLUSHED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (state_q)
            IDLE: begin
                if (is_read && tag_hit) begin
                    dhit     = 1'b1;
                    dmemload = cur_frame.data;
                end else if (sc_fail) begin
                    // Failed SC answers immediately with result 0.
                    dhit     = 1'b1;
                    dmemload = '0;
                end
            end
            RD: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
                if (!dwait) begin
                    dhit     = 1'b1;
                    dmemload = dload;
                end
            end
            WR: begin
                dWEN   = 1'b1;
                daddr  = {dmemaddr[31:2], 2'b00};
                dstore = dmemstore;
                if (!dwait) begin
                    dhit     = 1'b1;
                    dmemload = {31'd0, sc_q};
                end
            end
            FLUSHED: begin
                flushed = 1'b1;
            end
            default: begin
                dhit = 1'b0;
            end
        endcase
    end

    // Remember whether the write in flight is an SC so its completion can
    // report success regardless of link updates in the meantime.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sc_q <= is_sc;
        end
    end

    // -----------------------------------------------------------------------
    // Frame array: fill on read completion, update on write hit only.
    // -----------------------------------------------------------------------
    assign frame_we = xfer_done && ((state_q == RD) || tag_hit);

    always_comb begin
        frame_wdata       = '0;
        frame_wdata.valid = 1'b1;
        frame_wdata.tag   = tag_ext;
        frame_wdata.data  = (state_q == RD) ? dload : dmemstore;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NFRAMES; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else if (frame_we) begin
            frames_q[index] <= frame_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // LL/SC link register
    // -----------------------------------------------------------------------
    dcache_link_reg u_link (
        .CLK        (CLK),
        .RST        (RST),
        .ll_done_i  (dhit && is_ll),
        .ll_addr_i  (req_waddr),
        .sc_done_i  (dhit && is_sc),
        .wr_done_i  (xfer_done && (state_q == WR)),
        .wr_addr_i  (req_waddr),
        .sc_addr_i  (req_waddr),
        .match_o    (link_match)
    );

endmodule

// File: tb/tb_dcache_wt.sv
// ---------------------------------------------------------------------------
// tb_dcache_wt
// Directed testbench for dcache_wt: memory-side handshake driven per
// transaction with a programmable number of busy cycles.
// ---------------------------------------------------------------------------
module tb_dcache_wt;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic        datomic;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    int checks = 0;
    int errors = 0;

    dcache_wt #(.NFRAMES(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .halt      (halt),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .datomic   (datomic),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One datapath transaction. Requests are driven at the falling edge and
    // held until dhit; dwait stays high for 'waits' memory-request cycles.
    task automatic do_req(input string name, input logic rd, input logic wr, input logic at,
                          input logic [31:0] addr, input logic [31:0] store,
                          input int waits, input logic [31:0] load, input int halt_at,
                          output logic [31:0] data, output int cycles,
                          output int dren_n, output int dwen_n,
                          output logic [31:0] last_daddr, output logic [31:0] last_dstore);
        int          busy;
        logic        done;
        logic [31:0] idle_load;
        busy        = 0;
        done        = 1'b0;
        idle_load   = '0;
        data        = '0;
        cycles      = 0;
        dren_n      = 0;
        dwen_n      = 0;
        last_daddr  = '0;
        last_dstore = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            dmemREN   = rd;
            dmemWEN   = wr;
            datomic   = at;
            dmemaddr  = addr;
            dmemstore = store;
            if (c == halt_at) halt = 1'b1;
            dwait = (busy < waits);
            dload = load;
            #1;
            if (dREN) begin
                dren_n++;
                last_daddr = daddr;
            end
            if (dWEN) begin
                dwen_n++;
                last_daddr  = daddr;
                last_dstore = dstore;
            end
            if (dREN || dWEN) busy++;
            cycles = c + 1;
            if (dhit) begin
                data = dmemload;
                done = 1'b1;
            end else begin
                idle_load = idle_load | dmemload;
            end
        end
        check_eq({name, " dhit_seen"}, {31'd0, done}, 32'd1);
        check_eq({name, " load_when_no_hit"}, idle_load, 32'd0);
        $display("txn %-12s addr=0x%08h data=0x%08h cycles=%0d dREN=%0d dWEN=%0d",
                 name, addr, data, cycles, dren_n, dwen_n);
    endtask

    task automatic go_idle();
        @(negedge CLK);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        datomic = 1'b0;
        dwait   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, la, ls;
        int          cyc, nr, nw;
        logic        acc_hit, acc_ren;

        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = '0; dmemstore = '0; dwait = 1'b0; dload = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_eq("rst dhit", {31'd0, dhit}, 32'd0);
        check_eq("rst dmemload", dmemload, 32'd0);
        check_eq("rst flushed", {31'd0, flushed}, 32'd0);
        check_eq("rst dREN", {31'd0, dREN}, 32'd0);
        check_eq("rst dWEN", {31'd0, dWEN}, 32'd0);
        check_eq("rst daddr", daddr, 32'd0);
        check_eq("rst dstore", dstore, 32'd0);
        $display("txn reset       outputs sampled");

        // Cold read with 3 busy cycles, then same-cycle hit
        do_req("cold_rd", 1, 0, 0, 32'h100, 0, 3, 32'hDEADBEEF, -1, d, cyc, nr, nw, la, ls);
        check_eq("cold_rd data", d, 32'hDEADBEEF);
        check_eq("cold_rd dREN cycles", nr, 4);
        check_eq("cold_rd dWEN cycles", nw, 0);
        check_eq("cold_rd daddr", la, 32'h100);
        do_req("hit_rd", 1, 0, 0, 32'h100, 0, 3, 32'h0BADF00D, -1, d, cyc, nr, nw, la, ls);
        check_eq("hit_rd data", d, 32'hDEADBEEF);
        check_eq("hit_rd cycles", cyc, 1);
        check_eq("hit_rd dREN", nr, 0);

        // Write-through store on a hit, then read back from the cache
        do_req("store_hit", 0, 1, 0, 32'h100, 32'h12345678, 1, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("store_hit dWEN cycles", nw, 2);
        check_eq("store_hit dREN", nr, 0);
        check_eq("store_hit dstore", ls, 32'h12345678);
        check_eq("store_hit daddr", la, 32'h100);
        do_req("rd_after_st", 1, 0, 0, 32'h103, 0, 0, 32'h0, -1, d, cyc, nr, nw, la, ls);
        check_eq("rd_after_st data", d, 32'h12345678);
        check_eq("rd_after_st cycles", cyc, 1);

        // Conflict miss on the same index evicts the old line
        do_req("conflict", 1, 0, 0, 32'h140, 0, 0, 32'hAAAA5555, -1, d, cyc, nr, nw, la, ls);
        check_eq("conflict data", d, 32'hAAAA5555);
        check_eq("conflict cycles", cyc, 2);
        check_eq("conflict daddr", la, 32'h140);
        do_req("evicted", 1, 0, 0, 32'h100, 0, 0, 32'h12345678, -1, d, cyc, nr, nw, la, ls);
        check_eq("evicted cycles", cyc, 2);

        // Write miss does not allocate
        do_req("store_miss", 0, 1, 0, 32'h300, 32'h7, 0, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("store_miss dWEN", nw, 1);
        do_req("no_alloc", 1, 0, 0, 32'h100, 0, 0, 32'h0, -1, d, cyc, nr, nw, la, ls);
        check_eq("no_alloc cycles", cyc, 1);
        check_eq("no_alloc data", d, 32'h12345678);

        // LL then SC succeeds; second SC fails immediately
        do_req("ll", 1, 0, 1, 32'h200, 0, 0, 32'h11, -1, d, cyc, nr, nw, la, ls);
        check_eq("ll data", d, 32'h11);
        do_req("sc_ok", 0, 1, 1, 32'h200, 32'h5, 0, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("sc_ok result", d, 32'd1);
        check_eq("sc_ok dWEN", nw, 1);
        check_eq("sc_ok dstore", ls, 32'h5);
        do_req("sc_again", 0, 1, 1, 32'h200, 32'h6, 0, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("sc_again result", d, 32'd0);
        check_eq("sc_again cycles", cyc, 1);
        check_eq("sc_again dWEN", nw, 0);

        // LL, intervening store to the linked word, SC fails
        do_req("ll2", 1, 0, 1, 32'h200, 0, 0, 32'h0, -1, d, cyc, nr, nw, la, ls);
        check_eq("ll2 data", d, 32'h5);
        check_eq("ll2 cycles", cyc, 1);
        do_req("st_linked", 0, 1, 0, 32'h200, 32'h9, 0, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("st_linked dWEN", nw, 1);
        do_req("sc_broken", 0, 1, 1, 32'h200, 32'h8, 0, 0, -1, d, cyc, nr, nw, la, ls);
        check_eq("sc_broken result", d, 32'd0);
        check_eq("sc_broken dWEN", nw, 0);
        do_req("rd_linked", 1, 0, 0, 32'h200, 0, 0, 32'h0, -1, d, cyc, nr, nw, la, ls);
        check_eq("rd_linked data", d, 32'h9);

        // Read and write together is a write
        do_req("rd_and_wr", 1, 1, 0, 32'h400, 32'h55, 0, 32'h0, -1, d, cyc, nr, nw, la, ls);
        check_eq("rd_and_wr dWEN", nw, 1);
        check_eq("rd_and_wr dREN", nr, 0);

        // Reset during a write abandons it and clears the cache
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b1; datomic = 1'b0;
        dmemaddr = 32'h200; dmemstore = 32'h77; dwait = 1'b1;
        @(negedge CLK);
        #1;
        check_eq("rst_in_wr dWEN before", {31'd0, dWEN}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        dmemWEN = 1'b0;
        #1;
        check_eq("rst_in_wr dWEN after", {31'd0, dWEN}, 32'd0);
        check_eq("rst_in_wr dhit after", {31'd0, dhit}, 32'd0);
        $display("txn rst_in_wr   addr=0x00000200 transfer abandoned");
        do_req("post_rst_rd", 1, 0, 0, 32'h200, 0, 0, 32'h33, -1, d, cyc, nr, nw, la, ls);
        check_eq("post_rst_rd cycles", cyc, 2);
        check_eq("post_rst_rd data", d, 32'h33);

        // Halt mid-read: read completes, one IDLE cycle, then flushed
        do_req("halt_rd", 1, 0, 0, 32'h500, 0, 2, 32'hCAFEF00D, 1, d, cyc, nr, nw, la, ls);
        check_eq("halt_rd data", d, 32'hCAFEF00D);
        check_eq("halt_rd dREN cycles", nr, 3);
        go_idle();
        #1;
        check_eq("halt idle flushed", {31'd0, flushed}, 32'd0);
        @(negedge CLK);
        #1;
        check_eq("halt flushed", {31'd0, flushed}, 32'd1);
        acc_hit = 1'b0;
        acc_ren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            dmemREN = 1'b1;
            dmemaddr = 32'h500;
            #1;
            acc_hit = acc_hit | dhit;
            acc_ren = acc_ren | dREN | dWEN;
        end
        check_eq("flushed no dhit", {31'd0, acc_hit}, 32'd0);
        check_eq("flushed no mem req", {31'd0, acc_ren}, 32'd0);
        check_eq("flushed sticky", {31'd0, flushed}, 32'd1);
        $display("txn flushed     requests ignored");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
